// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, IR field positions and the fetch-state enum.
// Both the fetch unit and the control unit import these.
package cpu_pkg;

  localparam logic [2:0] OP_LW   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 7;
  localparam int RT_MSB  = 6;
  localparam int RT_LSB  = 4;
  localparam int IMM_MSB = 6;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALTED
  } fetch_state_t;

  // Opcodes that need the datapath and therefore wait for exec_done.
  function automatic logic is_exec_op(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_ADD);
  endfunction

  function automatic logic [7:0] sext_imm(input logic [6:0] field);
    return {field[6], field};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus between the fetch unit (slave) and its controller/datapath side (master):
// program-load port, start/exec_done handshake and the decoded IR fields.
interface instr_fetch_unit_if #(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 6
);

  logic               start;
  logic               load_en;
  logic [PC_W-1:0]    load_addr;
  logic [INSTR_W-1:0] load_data;
  logic               exec_done;

  logic [2:0]         opcode;
  logic [2:0]         rd;
  logic [2:0]         rs;
  logic [2:0]         rt;
  logic [7:0]         imm;
  logic               instr_valid;
  logic [PC_W-1:0]    pc;
  logic               busy;
  logic               halted;

  modport master (
    output start, load_en, load_addr, load_data, exec_done,
    input  opcode, rd, rs, rt, imm, instr_valid, pc, busy, halted
  );

  modport slave (
    input  start, load_en, load_addr, load_data, exec_done,
    output opcode, rd, rs, rt, imm, instr_valid, pc, busy, halted
  );

endinterface

// File: rtl/instr_fetch_unit_mem.sv
// Instruction store: synchronous write port for program loading, asynchronous read
// port so FETCH sees the word at pc (including one written on the same edge as start).
module instr_mem #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_array [0:(2**ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_array[waddr] <= wdata;
    end
  end

  assign rdata = mem_array[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch/decode sequencer: PC, loadable instruction memory and IR.
// Optional macro IFU_JUMP_EN turns opcode 110 into an absolute jump to imm.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int         INSTR_W = 16,
  parameter int         PC_W    = 6,
  parameter logic [2:0] HALT_OP = OP_HALT
) (
  input logic              clk,
  input logic              reset,
  instr_fetch_unit_if.slave bus
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  fetch_state_t       state_reg, state_next;
  logic [PC_W-1:0]    pc_reg, pc_next;
  logic [INSTR_W-1:0] ir_reg, ir_next;
  logic [INSTR_W-1:0] mem_rdata;
  logic               mem_we;
  logic [2:0]         opcode;

  assign opcode = ir_reg[OPC_MSB:OPC_LSB];

  // Program loading is only allowed while the sequencer is parked.
  assign mem_we = bus.load_en && ((state_reg == ST_IDLE) || (state_reg == ST_HALTED));

  instr_mem #(
    .ADDR_W (PC_W),
    .DATA_W (INSTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (bus.load_addr),
    .wdata (bus.load_data),
    .raddr (pc_reg),
    .rdata (mem_rdata)
  );

`ifdef IFU_JUMP_EN
  // Jump target: low imm bits, zero-extended when the PC is wider than the field.
  logic [PC_W-1:0] jmp_target;
  genvar gi;
  generate
    for (gi = 0; gi < PC_W; gi++) begin : g_jmp
      if (gi <= IMM_MSB) begin : g_low
        assign jmp_target[gi] = ir_reg[IMM_LSB + gi];
      end else begin : g_zero
        assign jmp_target[gi] = 1'b0;
      end
    end
  endgenerate
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      pc_reg    <= '0;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    case (state_reg)
      ST_IDLE, ST_HALTED: begin
        if (bus.start) begin
          pc_next    = '0;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        ir_next    = mem_rdata;
        state_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (opcode == HALT_OP) begin
          state_next = ST_HALTED;
        end else if (is_exec_op(opcode)) begin
          state_next = ST_EXEC;
`ifdef IFU_JUMP_EN
        end else if (opcode == OP_JMP) begin
          pc_next    = jmp_target;
          state_next = ST_FETCH;
`endif
        end else begin
          pc_next    = pc_reg + PC_ONE;
          state_next = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (bus.exec_done) begin
          pc_next    = pc_reg + PC_ONE;
          state_next = ST_FETCH;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.opcode      = opcode;
  assign bus.rd          = ir_reg[RD_MSB:RD_LSB];
  assign bus.rs          = ir_reg[RS_MSB:RS_LSB];
  assign bus.rt          = ir_reg[RT_MSB:RT_LSB];
  assign bus.imm         = sext_imm(ir_reg[IMM_MSB:IMM_LSB]);
  assign bus.pc          = pc_reg;
  assign bus.instr_valid = (state_reg == ST_DECODE) || (state_reg == ST_EXEC);
  assign bus.busy        = (state_reg != ST_IDLE) && (state_reg != ST_HALTED);
  assign bus.halted      = (state_reg == ST_HALTED);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequencing, NOPs, load gating, wrap,
// async reset, field decode and (build-dependent) the IFU_JUMP_EN jump.
module tb_instr_fetch_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  instr_fetch_unit_if #(.INSTR_W(16), .PC_W(6)) bus ();

  instr_fetch_unit #(
    .INSTR_W (16),
    .PC_W    (6),
    .HALT_OP (3'b111)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic load_word(input logic [5:0] addr, input logic [15:0] data);
    bus.load_en   = 1'b1;
    bus.load_addr = addr;
    bus.load_data = data;
    tick();
    bus.load_en   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_halted(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!bus.halted && n < max_cycles) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.halted), 32'd1);
  endtask

  initial begin
    int n;
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.exec_done = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_pc",     32'(bus.pc),          32'd0);
    check("rst_opcode", 32'(bus.opcode),      32'd0);
    check("rst_valid",  32'(bus.instr_valid), 32'd0);
    check("rst_busy",   32'(bus.busy),        32'd0);
    check("rst_halted", 32'(bus.halted),      32'd0);
    reset = 1'b0;

    // Basic sequencing: add then halt
    load_word(6'd0, 16'h4000);
    load_word(6'd1, 16'hE000);
    pulse_start();
    check("basic_c1_busy",  32'(bus.busy),        32'd1);
    check("basic_c1_valid", 32'(bus.instr_valid), 32'd0);
    tick();
    check("basic_c2_opcode", 32'(bus.opcode),      32'd2);
    check("basic_c2_valid",  32'(bus.instr_valid), 32'd1);
    check("basic_c2_pc",     32'(bus.pc),          32'd0);
    tick();
    check("basic_c3_valid", 32'(bus.instr_valid), 32'd1);
    bus.exec_done = 1'b1;
    tick();
    bus.exec_done = 1'b0;
    check("basic_c4_pc",    32'(bus.pc),          32'd1);
    check("basic_c4_valid", 32'(bus.instr_valid), 32'd0);
    tick();
    check("basic_c5_pc",     32'(bus.pc),     32'd1);
    check("basic_c5_opcode", 32'(bus.opcode), 32'd7);
    tick();
    check("basic_c6_halted", 32'(bus.halted), 32'd1);
    check("basic_c6_busy",   32'(bus.busy),   32'd0);
    check("basic_c6_pc",     32'(bus.pc),     32'd1);
    bus.exec_done = 1'b1;
    tick();
    bus.exec_done = 1'b0;
    check("halt_ignores_done_pc", 32'(bus.pc),     32'd1);
    check("halt_ignores_done_st", 32'(bus.halted), 32'd1);

    // NOP handling, plus start while busy
    load_word(6'd0, 16'h6000);
    pulse_start();
    tick();
    check("nop_c2_opcode", 32'(bus.opcode),      32'd3);
    check("nop_c2_pc",     32'(bus.pc),          32'd0);
    tick();
    check("nop_c3_pc",    32'(bus.pc),          32'd1);
    check("nop_c3_valid", 32'(bus.instr_valid), 32'd0);
    pulse_start();
    check("busy_start_ignored_pc", 32'(bus.pc),     32'd1);
    check("nop_c4_opcode",         32'(bus.opcode), 32'd7);
    tick();
    check("nop_c5_halted", 32'(bus.halted), 32'd1);

    // Load port gating while busy
    for (int i = 0; i < 5; i++) load_word(6'(i), 16'h6000);
    load_word(6'd5, 16'hE000);
    pulse_start();
    bus.load_en   = 1'b1;
    bus.load_addr = 6'd5;
    bus.load_data = 16'h2000;
    tick();
    bus.load_en   = 1'b0;
    wait_halted("gate_halt_timeout", 40);
    check("gate_pc",     32'(bus.pc),     32'd5);
    check("gate_opcode", 32'(bus.opcode), 32'd7);

    // Same-cycle load and start
    bus.load_en   = 1'b1;
    bus.load_addr = 6'd0;
    bus.load_data = 16'h2000;
    bus.start     = 1'b1;
    tick();
    bus.load_en   = 1'b0;
    bus.start     = 1'b0;
    tick();
    check("same_opcode", 32'(bus.opcode),      32'd1);
    check("same_pc",     32'(bus.pc),          32'd0);
    check("same_valid",  32'(bus.instr_valid), 32'd1);
    tick();
    tick();
    tick();
    check("exec_hold_valid", 32'(bus.instr_valid), 32'd1);
    check("exec_hold_pc",    32'(bus.pc),          32'd0);

    // Asynchronous reset in EXEC
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy",   32'(bus.busy),        32'd0);
    check("arst_pc",     32'(bus.pc),          32'd0);
    check("arst_opcode", 32'(bus.opcode),      32'd0);
    check("arst_valid",  32'(bus.instr_valid), 32'd0);
    check("arst_halted", 32'(bus.halted),      32'd0);
    tick();
    reset = 1'b0;
    pulse_start();
    tick();
    check("rerun_opcode", 32'(bus.opcode), 32'd1);
    tick();
    bus.exec_done = 1'b1;
    tick();
    bus.exec_done = 1'b0;
    check("rerun_pc", 32'(bus.pc), 32'd1);
    reset_dut();

    // Field decode with negative and positive immediates
    load_word(6'd0, 16'h55F9);
    load_word(6'd1, 16'h2035);
    pulse_start();
    tick();
    check("fld0_opcode", 32'(bus.opcode), 32'd2);
    check("fld0_rd",     32'(bus.rd),     32'd5);
    check("fld0_rs",     32'(bus.rs),     32'd3);
    check("fld0_rt",     32'(bus.rt),     32'd7);
    check("fld0_imm",    32'(bus.imm),    32'hF9);
    tick();
    bus.exec_done = 1'b1;
    tick();
    bus.exec_done = 1'b0;
    tick();
    check("fld1_opcode", 32'(bus.opcode), 32'd1);
    check("fld1_rd",     32'(bus.rd),     32'd0);
    check("fld1_rt",     32'(bus.rt),     32'd3);
    check("fld1_imm",    32'(bus.imm),    32'h35);
    reset_dut();

    // PC wrap-around at address 63
    for (int i = 0; i < 63; i++) load_word(6'(i), 16'h6000);
    load_word(6'd63, 16'h2000);
    pulse_start();
    n = 0;
    while (!(bus.instr_valid && bus.pc == 6'd63) && n < 200) begin
      tick();
      n++;
    end
    check("wrap_reach_63", 32'(bus.pc),     32'd63);
    check("wrap_opcode",   32'(bus.opcode), 32'd1);
    tick();
    bus.exec_done = 1'b1;
    tick();
    bus.exec_done = 1'b0;
    check("wrap_pc",    32'(bus.pc),          32'd0);
    check("wrap_busy",  32'(bus.busy),        32'd1);
    check("wrap_valid", 32'(bus.instr_valid), 32'd0);
    reset_dut();

    // Opcode 110: jump when IFU_JUMP_EN, otherwise NOP
    load_word(6'd0, 16'hC00A);
    pulse_start();
    tick();
    check("jmp_opcode", 32'(bus.opcode), 32'd6);
    check("jmp_imm",    32'(bus.imm),    32'h0A);
    tick();
`ifdef IFU_JUMP_EN
    check("jmp_pc", 32'(bus.pc), 32'd10);
`else
    check("jmp_pc", 32'(bus.pc), 32'd1);
`endif
    check("jmp_valid", 32'(bus.instr_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
